// File: rtl/pipe_multiplier.sv
// -----------------------------------------------------------------------------
// pipe_multiplier
//   Fully pipelined shift-add multiplier with valid/ready handshaking.
//   Operands are reduced to magnitudes in the input stage, one multiplier bit
//   is consumed per shift-add stage, and the output stage re-applies the sign.
//   The pipeline is rigid: all stages advance together unless the output is
//   held by the consumer, in which case every stage freezes.
//
// Parameters
//   M : multiplicand width (>= 2)
//   N : multiplier width and number of shift-add stages (>= 2)
//
// Ports
//   clk        : clock, all state on rising edge
//   rst_n      : asynchronous active-low reset
//   in_valid   : operand pair offered
//   in_ready   : operand pair can be accepted this cycle
//   in_signed  : 1 = two's-complement operands, 0 = unsigned
//   multi1     : multiplicand, M bits
//   multi2     : multiplier, N bits
//   out_valid  : product valid
//   out_ready  : consumer accepts product
//   product    : M+N bit result (0 while out_valid = 0)
//   occupancy  : number of transactions currently held in the pipeline
// -----------------------------------------------------------------------------
module pipe_multiplier #(
  parameter int M = 4,
  parameter int N = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic                       in_signed,
  input  logic [M-1:0]               multi1,
  input  logic [N-1:0]               multi2,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [M+N-1:0]             product,
  output logic [$clog2(N+3)-1:0]     occupancy
);

  localparam int W     = M + N;
  localparam int OCC_W = $clog2(N + 3);

  // Magnitude of the multiplicand, zero-extended to the full product width.
  // The most negative value maps onto itself as a bit pattern, which read as
  // unsigned is exactly 2^(M-1), so no extra bit is needed.
  function automatic logic [W-1:0] mag_m(input logic [M-1:0] v, input logic sgn);
    logic signed [M-1:0] s;
    s = $signed(v);
    if (sgn && v[M-1]) s = -s;
    return {{N{1'b0}}, $unsigned(s)};
  endfunction

  // Magnitude of the multiplier; only its N bits are carried down the pipe.
  function automatic logic [N-1:0] mag_n(input logic [N-1:0] v, input logic sgn);
    logic signed [N-1:0] s;
    s = $signed(v);
    if (sgn && v[N-1]) s = -s;
    return $unsigned(s);
  endfunction

  // Two's-complement negation of the accumulated magnitude.
  function automatic logic [W-1:0] negate_w(input logic [W-1:0] v);
    logic signed [W-1:0] s;
    s = $signed(v);
    s = -s;
    return $unsigned(s);
  endfunction

  // Index 0 is the input stage S0, index k (1..N) is shift-add stage Sk.
  logic [W-1:0] mcand_p  [0:N];
  logic [N-1:0] mplier_p [0:N];
  logic [W-1:0] acc_p    [0:N];
  logic [N:0]   vld_p;
  logic [N:0]   neg_p;

  logic stall;
  logic advance;
  logic accept;
  logic out_hs;
  logic [W-1:0] final_mag;

  assign stall    = out_valid & ~out_ready;
  assign advance  = ~stall;
  assign in_ready = advance;
  assign accept   = in_valid & in_ready;
  assign out_hs   = out_valid & out_ready;

  assign final_mag = neg_p[N] ? negate_w(acc_p[N]) : acc_p[N];

  // ---- S0: operand capture (magnitudes + negate flag) ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p[0]    <= 1'b0;
      neg_p[0]    <= 1'b0;
      mcand_p[0]  <= '0;
      mplier_p[0] <= '0;
      acc_p[0]    <= '0;
    end else if (advance) begin
      vld_p[0]    <= in_valid;
      neg_p[0]    <= in_signed & (multi1[M-1] ^ multi2[N-1]);
      mcand_p[0]  <= mag_m(multi1, in_signed);
      mplier_p[0] <= mag_n(multi2, in_signed);
      acc_p[0]    <= '0;
    end
  end

  // ---- S1..SN: one multiplier bit per stage ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 1; k <= N; k++) begin
        vld_p[k]    <= 1'b0;
        neg_p[k]    <= 1'b0;
        mcand_p[k]  <= '0;
        mplier_p[k] <= '0;
        acc_p[k]    <= '0;
      end
    end else if (advance) begin
      for (int k = 1; k <= N; k++) begin
        vld_p[k]    <= vld_p[k-1];
        neg_p[k]    <= neg_p[k-1];
        acc_p[k]    <= mplier_p[k-1][0] ? (acc_p[k-1] + mcand_p[k-1]) : acc_p[k-1];
        mcand_p[k]  <= mcand_p[k-1] << 1;
        mplier_p[k] <= mplier_p[k-1] >> 1;
      end
    end
  end

  // ---- SO: sign restore; product forced to 0 for bubbles ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      product   <= '0;
    end else if (advance) begin
      out_valid <= vld_p[N];
      product   <= vld_p[N] ? final_mag : '0;
    end
  end

  // Transaction count: up on acceptance, down on output handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      occupancy <= '0;
    end else begin
      case ({accept, out_hs})
        2'b10:   occupancy <= occupancy + OCC_W'(1);
        2'b01:   occupancy <= occupancy - OCC_W'(1);
        default: occupancy <= occupancy;
      endcase
    end
  end

endmodule

// File: tb/tb_pipe_multiplier.sv
module tb_pipe_multiplier;

  localparam int M = 4;
  localparam int N = 4;
  localparam int W = M + N;

  logic             clk;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic             in_signed;
  logic [M-1:0]     multi1;
  logic [N-1:0]     multi2;
  logic             out_valid;
  logic             out_ready;
  logic [W-1:0]     product;
  logic [$clog2(N+3)-1:0] occupancy;

  pipe_multiplier #(.M(M), .N(N)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_signed (in_signed),
    .multi1    (multi1),
    .multi2    (multi2),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .product   (product),
    .occupancy (occupancy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  logic [W-1:0] exp_q[$];
  int hs_n, hs_first, hs_last;
  int peak;
  bit peak_en = 0;

  typedef struct {
    logic         sgn;
    logic [M-1:0] a;
    logic [N-1:0] b;
    logic [W-1:0] exp;
  } vec_t;

  vec_t tbl[10];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic logic [W-1:0] model(input logic s, input logic [M-1:0] a, input logic [N-1:0] b);
    int ia, ib, p;
    ia = s ? int'($signed(a)) : int'(a);
    ib = s ? int'($signed(b)) : int'(b);
    p  = ia * ib;
    return p[W-1:0];
  endfunction

  // Scoreboard: push on acceptance, pop and compare on output handshake.
  always @(negedge clk) begin
    if (rst_n) begin
      if (peak_en && int'(occupancy) > peak) peak = int'(occupancy);
      if (in_valid && in_ready) exp_q.push_back(model(in_signed, multi1, multi2));
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL sb_unexpected: product %0h with nothing outstanding (t=%0t)", product, $time);
        end else begin
          chk("sb_product", product, exp_q.pop_front());
          if (hs_n == 0) hs_first = cyc;
          hs_last = cyc;
          hs_n++;
        end
      end
      if (!out_valid) chk("idle_zero", product, '0);
    end
  end

  // Offer one operand pair and hold it until accepted (bounded).
  task automatic send(input logic s, input logic [M-1:0] a, input logic [N-1:0] b);
    bit acc;
    in_signed = s;
    multi1    = a;
    multi2    = b;
    in_valid  = 1'b1;
    acc = 0;
    for (int i = 0; i < 30 && !acc; i++) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
    end
    if (!acc) begin
      total++;
      bad++;
      $display("FAIL send_timeout: in_ready stayed %0d expected 1", in_ready);
    end
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int i;
    for (i = 0; i < 40 && exp_q.size() != 0; i++) begin
      @(posedge clk);
      #1;
    end
    chk("drain_outstanding", exp_q.size(), 0);
  endtask

  initial begin
    tbl[0] = '{1'b0, 4'd13, 4'd11, 8'h8F};
    tbl[1] = '{1'b1, 4'h8,  4'h8,  8'h40};
    tbl[2] = '{1'b1, 4'h8,  4'h7,  8'hC8};
    tbl[3] = '{1'b1, 4'h5,  4'hF,  8'hFB};
    tbl[4] = '{1'b1, 4'h0,  4'hD,  8'h00};
    tbl[5] = '{1'b0, 4'hF,  4'hF,  8'hE1};
    tbl[6] = '{1'b1, 4'hF,  4'hF,  8'h01};
    tbl[7] = '{1'b1, 4'h7,  4'h8,  8'hC8};
    tbl[8] = '{1'b0, 4'h8,  4'h8,  8'h40};
    tbl[9] = '{1'b0, 4'h0,  4'h0,  8'h00};

    rst_n = 1'b0; in_valid = 1'b0; in_signed = 1'b0;
    multi1 = '0; multi2 = '0; out_ready = 1'b1;
    hs_n = 0; hs_first = 0; hs_last = 0; peak = 0;

    #2;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_product",   product,   0);
    chk("rst_occupancy", occupancy, 0);
    chk("rst_in_ready",  in_ready,  1);
    repeat (2) @(posedge clk);
    #1;

    // Single transactions; the first is offered together with reset release.
    for (int i = 0; i < 10; i++) begin
      rst_n     = 1'b1;
      in_signed = tbl[i].sgn;
      multi1    = tbl[i].a;
      multi2    = tbl[i].b;
      in_valid  = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      chk("tbl_occ_in", occupancy, 1);
      repeat (4) @(posedge clk);
      #1;
      chk("tbl_early_valid", out_valid, 0);
      @(posedge clk);
      #1;
      chk("tbl_valid", out_valid, 1);
      chk("tbl_product", product, tbl[i].exp);
      @(posedge clk);
      #1;
      chk("tbl_occ_out", occupancy, 0);
    end

    // Back-to-back streaming, alternating signed/unsigned.
    hs_n = 0; peak = 0; peak_en = 1;
    for (int i = 0; i < 8; i++)
      send(i[0], 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
    drain();
    peak_en = 0;
    chk("stream_count", hs_n, 8);
    chk("stream_consecutive", hs_last - hs_first, 7);
    chk("stream_peak_occ", peak, 6);

    // Backpressure with 15x15 at the output.
    out_ready = 1'b0;
    send(1'b0, 4'hF, 4'hF);
    send(1'b1, 4'h3, 4'hB);
    send(1'b0, 4'h6, 4'h9);
    for (int i = 0; i < 20 && !out_valid; i++) begin
      @(posedge clk);
      #1;
    end
    in_signed = 1'b1; multi1 = 4'h9; multi2 = 4'h6; in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("bp_out_valid", out_valid, 1);
      chk("bp_product",   product,   8'hE1);
      chk("bp_in_ready",  in_ready,  0);
      chk("bp_occupancy", occupancy, 3);
      @(posedge clk);
      #1;
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    chk("bp_occ_release", occupancy, 3);
    drain();
    chk("bp_occ_final", occupancy, 0);

    // Reset with three transactions in flight.
    send(1'b0, 4'hA, 4'h3);
    send(1'b1, 4'hC, 4'h5);
    send(1'b0, 4'h7, 4'h7);
    chk("mid_occ_before", occupancy, 3);
    rst_n = 1'b0;
    exp_q.delete();
    #1;
    chk("mid_rst_out_valid", out_valid, 0);
    chk("mid_rst_occupancy", occupancy, 0);
    chk("mid_rst_product",   product,   0);
    chk("mid_rst_in_ready",  in_ready,  1);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk);
      #1;
      chk("post_rst_no_output", out_valid, 0);
    end
    chk("post_rst_occ", occupancy, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
